// File: rtl/adpll_pkg.sv
// Shared types for the ADPLL modulation sequencer: mode codes, FSM states
// and the PRBS feedback tap masks.
package adpll_pkg;

  typedef enum logic [1:0] {
    MODE_PD   = 2'd0,
    MODE_TEST = 2'd1,
    MODE_RX   = 2'd2,
    MODE_TX   = 2'd3
  } adpll_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK,
    SETTLE,
    PREAMBLE,
    PAYLOAD,
    DONE
  } mod_state_t;

  // Bit i set means register stage i feeds the XOR; unknown orders fall back to PRBS9.
  function automatic logic [15:0] prbs_taps(input int ord);
    case (ord)
      7:       return 16'h0060;
      15:      return 16'h6000;
      default: return 16'h0110;
    endcase
  endfunction

endpackage

// File: rtl/adpll_mod_seq_if.sv
// Register-file / ADPLL side bundle of the modulation sequencer: controls,
// burst configuration and the sequencer outputs.
interface adpll_mod_seq_if #(
  parameter int DIVW     = 5,
  parameter int PRBS_ORD = 9,
  parameter int PREW     = 8,
  parameter int PAYW     = 16
);
  logic                en;
  logic [1:0]          adpll_mode;
  logic                channel_lock;
  logic [DIVW-1:0]     sym_div;
  logic [PREW-1:0]     pre_len;
  logic [PAYW-1:0]     pay_len;
  logic [PRBS_ORD-1:0] seed;
  logic                data_mod;
  logic                sym_strobe;
  logic                busy;
  logic                done;
  logic                lock_err;

  modport master (
    output en, adpll_mode, channel_lock, sym_div, pre_len, pay_len, seed,
    input  data_mod, sym_strobe, busy, done, lock_err
  );

  modport slave (
    input  en, adpll_mode, channel_lock, sym_div, pre_len, pay_len, seed,
    output data_mod, sym_strobe, busy, done, lock_err
  );
endinterface

// File: rtl/adpll_lfsr.sv
// Fibonacci PRBS generator; an all-zero seed is swapped for all-ones so the
// register can never lock up.
module adpll_lfsr
  import adpll_pkg::*;
#(
  parameter int ORD = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [ORD-1:0] seed,
  input  logic           step,
  output logic           bit_out
);
  localparam logic [15:0] TAPS_W = prbs_taps(ORD);
  localparam logic [ORD-1:0] TAPS = TAPS_W[ORD-1:0];

  logic [ORD-1:0] state;

  always_ff @(posedge clk) begin
    if (rst)
      state <= '1;
    else if (load)
      state <= (seed == '0) ? '1 : seed;
    else if (step)
      state <= {state[ORD-2:0], ^(state & TAPS)};
  end

  assign bit_out = state[ORD-1];
endmodule

// File: rtl/adpll_mod_seq.sv
// TX modulation-data sequencer: after a settled channel lock it emits one
// burst (alternating preamble, then PRBS payload) at a programmable symbol rate.
module adpll_mod_seq
  import adpll_pkg::*;
#(
  parameter int DIVW       = 5,
  parameter int PRBS_ORD   = 9,
  parameter int PREW       = 8,
  parameter int PAYW       = 16,
  parameter int SETTLE_CYC = 64
) (
  input logic            clk,
  input logic            rst,
  adpll_mod_seq_if.slave bus
);
  localparam int CNTW = (PAYW > PREW) ? PAYW : PREW;
  localparam int SW   = $clog2(SETTLE_CYC + 1);

  mod_state_t          state;
  logic [DIVW-1:0]     div_r, div_cnt;
  logic [PREW-1:0]     pre_r;
  logic [PAYW-1:0]     pay_r;
  logic [PRBS_ORD-1:0] seed_r;
  logic [CNTW-1:0]     sym_cnt;
  logic [SW-1:0]       settle_cnt;

  logic run, lock, wrap, in_burst, settle_done;
  logic lfsr_load, lfsr_step, lfsr_bit;
  logic [PRBS_ORD-1:0] lfsr_seed;

  always_comb begin
    run         = bus.en && (bus.adpll_mode == MODE_TX);
    lock        = bus.channel_lock;
    wrap        = (div_cnt == div_r);
    in_burst    = (state == PREAMBLE) || (state == PAYLOAD);
    settle_done = (state == SETTLE) && (settle_cnt == SW'(SETTLE_CYC - 1));
    // Entering PAYLOAD straight from SETTLE must use the live seed, since seed_r loads on that same edge.
    lfsr_seed   = (state == SETTLE) ? bus.seed : seed_r;
    lfsr_load   = run && lock &&
                  ((settle_done && bus.pre_len == '0 && bus.pay_len != '0) ||
                   (state == PREAMBLE && wrap && sym_cnt == CNTW'(pre_r) && pay_r != '0));
    lfsr_step   = run && lock && (state == PAYLOAD) && wrap && (sym_cnt != CNTW'(pay_r));
  end

  adpll_lfsr #(.ORD(PRBS_ORD)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .seed    (lfsr_seed),
    .step    (lfsr_step),
    .bit_out (lfsr_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.data_mod   <= 1'b0;
      bus.sym_strobe <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.lock_err   <= 1'b0;
      div_r          <= '0;
      div_cnt        <= '0;
      pre_r          <= '0;
      pay_r          <= '0;
      seed_r         <= '0;
      sym_cnt        <= '0;
      settle_cnt     <= '0;
    end else begin
      bus.sym_strobe <= 1'b0;
      if (!run) begin
        state        <= IDLE;
        bus.data_mod <= 1'b0;
        bus.busy     <= 1'b0;
        bus.done     <= 1'b0;
      end else if (in_burst && !lock) begin
        state        <= WAIT_LOCK;
        bus.lock_err <= 1'b1;
        bus.data_mod <= 1'b0;
        bus.busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state        <= WAIT_LOCK;
            bus.lock_err <= 1'b0;
          end
          WAIT_LOCK: begin
            if (lock) begin
              state      <= SETTLE;
              settle_cnt <= '0;
            end
          end
          SETTLE: begin
            if (!lock) begin
              state      <= WAIT_LOCK;
              settle_cnt <= '0;
            end else if (settle_done) begin
              div_r   <= bus.sym_div;
              pre_r   <= bus.pre_len;
              pay_r   <= bus.pay_len;
              seed_r  <= bus.seed;
              div_cnt <= bus.sym_div;
              sym_cnt <= '0;
              if (bus.pre_len != '0) begin
                state    <= PREAMBLE;
                bus.busy <= 1'b1;
              end else if (bus.pay_len != '0) begin
                state    <= PAYLOAD;
                bus.busy <= 1'b1;
              end else begin
                state    <= DONE;
                bus.done <= 1'b1;
              end
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          PREAMBLE: begin
            if (!wrap) begin
              div_cnt <= div_cnt + 1'b1;
            end else if (sym_cnt == CNTW'(pre_r)) begin
              bus.data_mod <= 1'b0;
              sym_cnt      <= '0;
              div_cnt      <= div_r;
              if (pay_r != '0) begin
                state <= PAYLOAD;
              end else begin
                state    <= DONE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
              end
            end else begin
              div_cnt        <= '0;
              bus.data_mod   <= sym_cnt[0];
              bus.sym_strobe <= 1'b1;
              sym_cnt        <= sym_cnt + 1'b1;
            end
          end
          PAYLOAD: begin
            if (!wrap) begin
              div_cnt <= div_cnt + 1'b1;
            end else if (sym_cnt == CNTW'(pay_r)) begin
              state        <= DONE;
              bus.data_mod <= 1'b0;
              bus.busy     <= 1'b0;
              bus.done     <= 1'b1;
            end else begin
              div_cnt        <= '0;
              bus.data_mod   <= lfsr_bit;
              bus.sym_strobe <= 1'b1;
              sym_cnt        <= sym_cnt + 1'b1;
            end
          end
          DONE: begin
            bus.data_mod <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
